// File: rtl/pio_arb_pkg.sv
// Shared definitions for the PIO write arbiter: op codes, PIO
// register addresses, FSM state type and the op-to-address map.
package pio_arb_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLR   = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [2:0] PIO_ADDR_DATA = 3'd0;
    localparam logic [2:0] PIO_ADDR_SET  = 3'd4;
    localparam logic [2:0] PIO_ADDR_CLR  = 3'd5;

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    function automatic logic [2:0] op_addr(input logic [1:0] op);
        logic [2:0] a;
        a = PIO_ADDR_DATA;
        unique case (op)
            OP_SET:  a = PIO_ADDR_SET;
            OP_CLR:  a = PIO_ADDR_CLR;
            default: a = PIO_ADDR_DATA;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/pio_write_arbiter_rr.sv
// Combinational round-robin picker: first set bit of valid at or above ptr, wrapping.
// Ports: valid (requests), ptr (search start) -> grant (one-hot), idx, any.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int            k;
    logic [IW-1:0] kk;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        kk    = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            kk = IW'(k);
            if (!any && valid[kk]) begin
                any       = 1'b1;
                grant[kk] = 1'b1;
                idx       = kk;
            end
        end
    end

endmodule

// File: rtl/pio_write_arbiter.sv
// Avalon-MM write master sharing one PIO (data/set/clear map) among
// NUM_REQ requesters, round-robin, one single-cycle write per grant.
// Ports: clk, reset_n; req_valid/req_op/req_data in, req_ready out;
// avm_address/chipselect/write_n/writedata; shadow, grant_id, busy, err_pulse.
module pio_write_arbiter
    import pio_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 16,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [2:0]                avm_address,
    output logic                      avm_chipselect,
    output logic                      avm_write_n,
    output logic [31:0]               avm_writedata,
    output logic [DATA_W-1:0]         shadow,
    output logic [IW-1:0]             grant_id,
    output logic                      busy,
    output logic                      err_pulse
);

    state_t              state, state_nx;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       win_idx;
    logic [NUM_REQ-1:0]  win_grant;
    logic                win_any;
    logic [1:0]          win_op;
    logic [DATA_W-1:0]   win_data;
    logic                accept;
    logic [1:0]          op_q;
    logic [DATA_W-1:0]   data_q;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    always_comb begin
        win_op   = OP_WRITE;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IW'(i)) begin
                win_op   = req_op[2*i +: 2];
                win_data = req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    // Reserved ops are accepted but never reach the bus.
    always_comb begin
        state_nx  = state;
        req_ready = '0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_any) begin
                    req_ready = win_grant;
                    accept    = 1'b1;
                    if (win_op != OP_RSVD) state_nx = WRITE;
                end
            end
            WRITE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == WRITE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            ptr            <= '0;
            grant_id       <= '0;
            op_q           <= OP_WRITE;
            data_q         <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= '0;
            avm_writedata  <= '0;
            shadow         <= '0;
            err_pulse      <= 1'b0;
        end else begin
            state          <= state_nx;
            err_pulse      <= accept && (win_op == OP_RSVD);
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            if (accept) begin
                ptr      <= (win_idx == IW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
                grant_id <= win_idx;
                op_q     <= win_op;
                data_q   <= win_data;
                if (win_op != OP_RSVD) begin
                    avm_chipselect <= 1'b1;
                    avm_write_n    <= 1'b0;
                    avm_address    <= op_addr(win_op);
                    avm_writedata  <= 32'(win_data);
                end
            end
            // Mirror the slave's own register update on the strobe edge.
            if (state == WRITE) begin
                unique case (op_q)
                    OP_WRITE: shadow <= data_q;
                    OP_SET:   shadow <= shadow | data_q;
                    OP_CLR:   shadow <= shadow & ~data_q;
                    default:  shadow <= shadow;
                endcase
            end
        end
    end

endmodule
